ascon_inv_round: RTL and testbench

ASCON_INV_ROUND -- requirements
Module: ascon_inv_round

---
 rtl/ascon_inv_round.sv | 122 ++++++++++++
 tb/tb_ascon_inv_round.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_inv_round.sv
// Inverse of one ASCON permutation round (constant add, S-box, diffusion).
// The round constant is removed first. The per-row diffusion is undone by
// applying L_i^(2^k) for k = 0..5, one step per cycle. That product equals
// L_i^63, which is L_i^-1 because L_i^64 is the identity. A table lookup
// then undoes the S-box on all 64 columns in one cycle.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for in_valid; in_ready high
// LIN    | six diffusion-inverse steps, k = 0..5
// SBOX   | inverse S-box applied to all 64 columns
// DONE   | result held on output_A until out_ready
module ascon_inv_round #(
  parameter logic [63:0] C0 = 64'h00000000000000F0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] input_B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] output_A
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LIN  = 2'd1;
  localparam logic [1:0] S_SBOX = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] INV_SBOX [0:31] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  logic [1:0]   state;
  logic [2:0]   k;
  logic [319:0] work;
  logic [319:0] lin_next;
  logic [319:0] sbox_next;

  function automatic logic [63:0] ror_var(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  // Rotation amounts are (2^k * a) mod 64; the shift truncates to 6 bits.
  // An amount of 0 simply makes two terms cancel, so no special case.
  function automatic logic [63:0] lin_step(input logic [63:0] x, input logic [5:0] a,
                                           input logic [5:0] b, input logic [2:0] kk);
    logic [5:0] sa;
    logic [5:0] sb;
    sa = a << kk;
    sb = b << kk;
    return x ^ ror_var(x, sa) ^ ror_var(x, sb);
  endfunction

  // One diffusion-inverse step on all five rows for the current k.
  always_comb begin
    lin_next = '0;
    lin_next[319:256] = lin_step(work[319:256], 6'd19, 6'd28, k);
    lin_next[255:192] = lin_step(work[255:192], 6'd61, 6'd39, k);
    lin_next[191:128] = lin_step(work[191:128], 6'd1,  6'd6,  k);
    lin_next[127:64]  = lin_step(work[127:64],  6'd10, 6'd17, k);
    lin_next[63:0]    = lin_step(work[63:0],    6'd7,  6'd41, k);
  end

  // Inverse S-box per bit column; row 0 supplies the MSB of the index.
  always_comb begin
    logic [4:0] v;
    sbox_next = '0;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      v = INV_SBOX[{work[256+i], work[192+i], work[128+i], work[64+i], work[i]}];
      sbox_next[256+i] = v[4];
      sbox_next[192+i] = v[3];
      sbox_next[128+i] = v[2];
      sbox_next[64+i]  = v[1];
      sbox_next[i]     = v[0];
    end
  end

  // Control FSM, step counter and working register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= 3'd0;
      work  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= input_B ^ {128'b0, C0, 128'b0};
            k     <= 3'd0;
            state <= S_LIN;
          end
        end
        S_LIN: begin
          work <= lin_next;
          k    <= k + 3'd1;
          if (k == 3'd5) state <= S_SBOX;
        end
        S_SBOX: begin
          work  <= sbox_next;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign output_A  = work;

endmodule

// File: tb/tb_ascon_inv_round.sv
// Bench for ascon_inv_round. A forward-round model builds input_B from known A.
// Expected A and accept edges are queued when a state is driven. A monitor pops
// them when a result transfers, and checks both the data and the 7-edge latency.
module tb_ascon_inv_round;

  localparam logic [63:0] C0_F = 64'h00000000000000F0;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] input_B;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] output_A;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [319:0] exp_q[$];
  int           lat_q[$];
  int           acc_log[$];
  logic         prev_ov = 1'b0;

  typedef struct {
    logic [319:0] b;
    logic [319:0] a;
  } vec_t;

  vec_t tbl[323];

  ascon_inv_round #(.C0(C0_F)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_B(input_B), .out_valid(out_valid), .out_ready(out_ready),
    .output_A(output_A)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward round: bitsliced ASCON S-box, diffusion, constant into row 2.
  function automatic logic [319:0] fwd(input logic [319:0] a);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = a[319:256]; x1 = a[255:192]; x2 = a[191:128]; x3 = a[127:64]; x4 = a[63:0];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    x2 ^= C0_F;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept.
  task automatic send(input logic [319:0] b, input logic [319:0] a);
    int n;
    exp_q.push_back(a);
    input_B  = b;
    in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) check("accept_timeout", 320'(in_ready), 320'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("drain_timeout", 320'(exp_q.size()), 320'd0);
    @(negedge clk);
  endtask

  // Monitor: records accepts, checks latency on out_valid rise, scores transfers.
  initial begin
    logic [319:0] e;
    int ae;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        exp_q.delete();
        lat_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          lat_q.push_back(cyc + 1);
          acc_log.push_back(cyc + 1);
        end
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) check("unexpected_valid", 320'd1, 320'd0);
          else begin
            ae = lat_q.pop_front();
            check("latency", 320'(cyc - ae), 320'd7);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_output", output_A, 320'd0);
          else begin
            e = exp_q.pop_front();
            check("output_A", output_A, e);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [319:0] a, b, a2;
    int n, acc_before;

    tbl[0].b = {64'h0, 64'h0, 64'hFFFFFFFFFFFFFF0F, 64'h0, 64'h0};
    tbl[0].a = 320'h0;
    for (int i = 0; i < 320; i++) begin
      a = 320'd1 << i;
      tbl[i+1].a = a;
      tbl[i+1].b = fwd(a);
    end
    a = '1;
    tbl[321].a = a; tbl[321].b = fwd(a);
    a = {10{32'hA5C3_0F96}};
    tbl[322].a = a; tbl[322].b = fwd(a);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; input_B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("reset_in_ready", 320'(in_ready), 320'd1);
    check("reset_out_valid", 320'(out_valid), 320'd0);
    check("reset_output_A", output_A, 320'd0);
    @(negedge clk);

    // Zero vector, one-hot sweep and patterns.
    for (int i = 0; i < 323; i++) send(tbl[i].b, tbl[i].a);
    in_valid = 1'b0;
    drain();

    // Random round trips.
    for (int i = 0; i < 1000; i++) begin
      a = rnd320();
      send(fwd(a), a);
    end
    in_valid = 1'b0;
    drain();

    // Back-to-back: in_valid stays high. The next accept comes 9 edges later:
    // accept, 7 compute edges, and the consuming edge. No bypass is allowed.
    a = rnd320(); a2 = rnd320();
    send(fwd(a), a);
    send(fwd(a2), a2);
    in_valid = 1'b0;
    drain();
    check("b2b_accept_spacing",
          320'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 320'd9);

    // Backpressure: result held 20 cycles while inputs wiggle.
    out_ready = 1'b0;
    a = rnd320();
    send(fwd(a), a);
    in_valid = 1'b0;
    n = 0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("bp_valid_seen", 320'(out_valid), 320'd1);
    acc_before = acc_log.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      input_B  = rnd320();
      in_valid = ~in_valid;
      #1;
      check("bp_output_stable", output_A, a);
      check("bp_in_ready_low", 320'(in_ready), 320'd0);
    end
    check("bp_no_accept", 320'(acc_log.size() - acc_before), 320'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("bp_release_in_ready", 320'(in_ready), 320'd1);
    check("bp_release_out_valid", 320'(out_valid), 320'd0);
    check("bp_single_transfer", 320'(exp_q.size()), 320'd0);
    @(negedge clk);

    // Reset while in LIN with k = 3.
    send(tbl[0].b, tbl[0].a);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 320'(in_ready), 320'd1);
    check("midrst_out_valid", 320'(out_valid), 320'd0);
    check("midrst_output_A", output_A, 320'd0);
    @(negedge clk);
    send(tbl[0].b, tbl[0].a);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
